// File: rtl/muldiv_iter.sv
// Iterative RISC-V M-extension multiply/divide unit: shift-add multiply (MUL_STEP bits/cycle),
// restoring divide (1 bit/cycle), single-cycle divide-by-zero and overflow results.
module muldiv_iter #(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 4
) (
    input  logic            clk_core,
    input  logic            reset_n,
    input  logic            go,
    input  logic            kill,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN + 1);
    localparam int MW = XLEN + MUL_STEP;
    localparam int AW = 2 * XLEN;
    localparam logic [CW-1:0]   MUL_CYCLES = CW'(XLEN / MUL_STEP);
    localparam logic [CW-1:0]   DIV_CYCLES = CW'(XLEN);
    localparam logic [XLEN-1:0] MOST_NEG   = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIXUP, ST_DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q;
    logic [AW-1:0]   acc_q;
    logic [XLEN-1:0] opnd_q;
    logic [2:0]      op_q;
    logic            sign_a_q, sign_b_q;

    logic            is_div, signed_a, signed_b, neg_a, neg_b;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] mag_a, mag_b, special_res;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        is_div      = op[2];
        signed_a    = is_div ? ~op[0] : (op[1:0] == 2'b01 || op[1:0] == 2'b10);
        signed_b    = is_div ? ~op[0] : (op[1:0] == 2'b01);
        neg_a       = signed_a & a[XLEN-1];
        neg_b       = signed_b & b[XLEN-1];
        mag_a       = neg_a ? -a : a;
        mag_b       = neg_b ? -b : b;
        div_zero    = (b == '0);
        div_ovf     = ~op[0] && (a == MOST_NEG) && (b == '1);
        special     = is_div && (div_zero || div_ovf);
        special_res = op[1] ? '0 : a;
        if (div_zero) special_res = op[1] ? a : '1;
    end

    // Multiplier lives in the low half of acc and is consumed as the product shifts in.
    logic [MUL_STEP-1:0] mul_digit;
    logic [MW-1:0]       mul_sum;
    logic [AW-1:0]       mul_next;
    logic [XLEN:0]       rem_shift;
    logic                div_ok;
    logic [XLEN-1:0]     rem_next;
    logic [AW-1:0]       div_next;
    logic [AW-1:0]       prod_fix;
    logic [XLEN-1:0]     quot_fix, rem_fix, fix_res;

    always_comb begin
        mul_digit = acc_q[MUL_STEP-1:0];
        mul_sum   = MW'(acc_q[AW-1:XLEN]) + MW'(opnd_q) * MW'(mul_digit);
        mul_next  = AW'({mul_sum, acc_q[XLEN-1:0]} >> MUL_STEP);

        rem_shift = {acc_q[AW-1:XLEN], acc_q[XLEN-1]};
        div_ok    = (rem_shift >= {1'b0, opnd_q});
        rem_next  = div_ok ? XLEN'(rem_shift - {1'b0, opnd_q}) : rem_shift[XLEN-1:0];
        div_next  = {rem_next, acc_q[XLEN-2:0], div_ok};

        prod_fix  = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
        quot_fix  = (sign_a_q ^ sign_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix   = sign_a_q ? -acc_q[AW-1:XLEN] : acc_q[AW-1:XLEN];
        if (op_q[2])
            fix_res = op_q[1] ? rem_fix : quot_fix;
        else if (op_q[1:0] == 2'b00)
            fix_res = prod_fix[XLEN-1:0];
        else
            fix_res = prod_fix[AW-1:XLEN];
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (go) state_d = !is_div ? ST_MUL : (special ? ST_DONE : ST_DIV);
            ST_MUL,
            ST_DIV:   if (count_q == CW'(1)) state_d = ST_FIXUP;
            ST_FIXUP: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (kill) state_d = ST_IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_core or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge clk_core or negedge reset_n) begin
        if (!reset_n) begin
            count_q  <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            op_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            result   <= '0;
        end else if (kill) begin
            count_q <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: if (go) begin
                    op_q     <= op;
                    sign_a_q <= neg_a;
                    sign_b_q <= neg_b;
                    if (!is_div) begin
                        acc_q   <= {{XLEN{1'b0}}, mag_b};
                        opnd_q  <= mag_a;
                        count_q <= MUL_CYCLES;
                    end else if (special) begin
                        result  <= special_res;
                    end else begin
                        acc_q   <= {{XLEN{1'b0}}, mag_a};
                        opnd_q  <= mag_b;
                        count_q <= DIV_CYCLES;
                    end
                end
                ST_MUL: begin
                    acc_q   <= mul_next;
                    count_q <= count_q - CW'(1);
                end
                ST_DIV: begin
                    acc_q   <= div_next;
                    count_q <= count_q - CW'(1);
                end
                ST_FIXUP: result <= fix_res;
                default: ;
            endcase
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_muldiv_iter.sv
// Scoreboard bench for muldiv_iter: driver pushes expected result/latency, monitor checks each done.
module tb_muldiv_iter;

    localparam int XLEN     = 32;
    localparam int MUL_STEP = 4;
    localparam logic [31:0] MIN_INT = 32'h8000_0000;

    logic        clk_core = 1'b0;
    logic        reset_n  = 1'b0;
    logic        go       = 1'b0;
    logic        kill     = 1'b0;
    logic [2:0]  op       = '0;
    logic [31:0] a        = '0;
    logic [31:0] b        = '0;
    logic        busy, done;
    logic [31:0] result;

    logic [2:0]  go_sw = '0;
    logic [2:0]  busy_sw, done_sw;
    logic [31:0] result_sw [3];

    always #5 clk_core = ~clk_core;

    muldiv_iter #(.XLEN(XLEN), .MUL_STEP(MUL_STEP)) dut (
        .clk_core(clk_core), .reset_n(reset_n), .go(go), .kill(kill), .op(op),
        .a(a), .b(b), .busy(busy), .done(done), .result(result)
    );

    for (genvar g = 0; g < 3; g++) begin : g_sweep
        muldiv_iter #(.XLEN(XLEN), .MUL_STEP((g == 0) ? 1 : ((g == 1) ? 2 : 8))) u_sw (
            .clk_core(clk_core), .reset_n(reset_n), .go(go_sw[g]), .kill(kill), .op(op),
            .a(a), .b(b), .busy(busy_sw[g]), .done(done_sw[g]), .result(result_sw[g])
        );
    end

    typedef struct {
        logic [31:0] res;
        int          issue;
        int          lat;
        logic [2:0]  op;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic        done_prev = 1'b0;
    logic [31:0] last_result = '0;

    always @(posedge clk_core) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model straight from the RISC-V M-extension definitions.
    function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] x,
                                               input logic [31:0] y);
        longint      p;
        logic [63:0] pu;
        int          sx, sy;
        logic        ovf;
        sx  = x;
        sy  = y;
        ovf = (x == MIN_INT) && (y == 32'hFFFF_FFFF);
        case (o)
            3'b000:  return x * y;
            3'b001:  begin p = longint'(sx) * longint'(sy); return p[63:32]; end
            3'b010:  begin p = longint'(sx) * longint'({32'b0, y}); return p[63:32]; end
            3'b011:  begin pu = {32'b0, x} * {32'b0, y}; return pu[63:32]; end
            3'b100:  return (y == 0) ? 32'hFFFF_FFFF : (ovf ? x : 32'(sx / sy));
            3'b101:  return (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'b110:  return (y == 0) ? x : (ovf ? 32'd0 : 32'(sx % sy));
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] o, input logic [31:0] x,
                                       input logic [31:0] y, input int step);
        if (!o[2]) return XLEN / step + 2;
        if (y == 0 || (!o[0] && x == MIN_INT && y == 32'hFFFF_FFFF)) return 1;
        return XLEN + 2;
    endfunction

    always @(negedge clk_core) begin
        if (done) begin
            check("done_single_pulse", {31'b0, done_prev}, 32'd0);
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: result 0x%08h with no request outstanding", result);
            end else begin
                mon_e = sb_q.pop_front();
                check($sformatf("result op%0d", mon_e.op), result, mon_e.res);
                check($sformatf("latency op%0d", mon_e.op), 32'(cyc - mon_e.issue), 32'(mon_e.lat));
            end
        end
        done_prev = done;
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] exp_res, input int exp_lat, input bit hold);
        exp_t e;
        int   n;
        @(negedge clk_core);
        go = 1'b1; op = o; a = x; b = y;
        e.res = exp_res; e.lat = exp_lat; e.issue = cyc; e.op = o;
        sb_q.push_back(e);
        @(negedge clk_core);
        check("busy_after_accept", {31'b0, busy}, 32'd1);
        op = 3'($urandom); a = $urandom; b = $urandom;
        n = 1;
        while (!done && n < 100) begin
            @(negedge clk_core);
            n++;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout op%0d: no done within %0d cycles, expected latency %0d", o, n, exp_lat);
            if (sb_q.size() > 0) void'(sb_q.pop_back());
            go = 1'b0; kill = 1'b1;
            @(negedge clk_core);
            kill = 1'b0;
            return;
        end
        if (hold) begin
            @(negedge clk_core);
            check("go_held_no_restart", {31'b0, busy}, 32'd0);
        end
        go = 1'b0;
        last_result = exp_res;
    endtask

    task automatic issue_rand(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        issue(o, x, y, ref_result(o, x, y), ref_latency(o, x, y, MUL_STEP), 1'b0);
    endtask

    task automatic sweep(input int g, input int reps);
        for (int r = 0; r < reps; r++) begin
            logic [2:0]  o;
            logic [31:0] x, y, exp_res;
            int          iss, n, step;
            step = (g == 0) ? 1 : ((g == 1) ? 2 : 8);
            o = 3'($urandom_range(0, 3)); x = $urandom; y = $urandom;
            @(negedge clk_core);
            go_sw[g] = 1'b1; op = o; a = x; b = y;
            iss = cyc;
            exp_res = ref_result(o, x, y);
            n = 0;
            do begin
                @(negedge clk_core);
                n++;
            end while (!done_sw[g] && n < 100);
            if (!done_sw[g]) begin
                n_checks++;
                n_fail++;
                $display("FAIL sweep_timeout step%0d: no done within %0d cycles", step, n);
            end else begin
                check($sformatf("sweep_result step%0d", step), result_sw[g], exp_res);
                check($sformatf("sweep_latency step%0d", step), 32'(cyc - iss), 32'(XLEN / step + 2));
            end
            go_sw[g] = 1'b0;
            @(negedge clk_core);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached after %0d checks", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        repeat (2) @(negedge clk_core);
        reset_n = 1'b1;

        issue(3'b000, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFF1, 10, 1'b0);
        issue(3'b001, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 10, 1'b0);
        issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 10, 1'b0);
        issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 10, 1'b0);
        issue(3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 34, 1'b0);
        issue(3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 34, 1'b0);
        issue(3'b101, 32'd100,       32'd7,        32'd14,        34, 1'b0);
        issue(3'b111, 32'd100,       32'd7,        32'd2,         34, 1'b0);
        issue(3'b101, 32'h0000_1234, 32'd0,        32'hFFFF_FFFF, 1,  1'b0);
        issue(3'b110, 32'h0000_1234, 32'd0,        32'h0000_1234, 1,  1'b0);
        issue(3'b100, MIN_INT,       32'hFFFF_FFFF, MIN_INT,      1,  1'b0);
        issue(3'b110, MIN_INT,       32'hFFFF_FFFF, 32'd0,        1,  1'b0);

        // Kill a divide in flight at cycle 5: no done, result untouched.
        @(negedge clk_core);
        go = 1'b1; op = 3'b100; a = 32'd1000; b = 32'd3;
        repeat (5) @(negedge clk_core);
        kill = 1'b1; go = 1'b0;
        @(negedge clk_core);
        kill = 1'b0;
        check("kill_busy", {31'b0, busy}, 32'd0);
        check("kill_result_held", result, last_result);
        repeat (3) @(negedge clk_core);

        issue(3'b000, 32'd3, 32'd4, 32'd12, 10, 1'b0);

        // kill together with go in IDLE must not start anything.
        @(negedge clk_core);
        go = 1'b1; kill = 1'b1; op = 3'b000; a = 32'd9; b = 32'd9;
        @(negedge clk_core);
        check("killgo_busy", {31'b0, busy}, 32'd0);
        go = 1'b0; kill = 1'b0;

        issue(3'b101, 32'd100, 32'd7, 32'd14, 34, 1'b1);

        // Async reset in the middle of a multiply.
        @(negedge clk_core);
        go = 1'b1; op = 3'b000; a = 32'd77; b = 32'd5;
        repeat (3) @(negedge clk_core);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_busy", {31'b0, busy}, 32'd0);
        check("async_reset_done", {31'b0, done}, 32'd0);
        check("async_reset_result", result, 32'd0);
        go = 1'b0;
        @(negedge clk_core);
        reset_n = 1'b1;
        last_result = '0;

        for (int i = 0; i < 150; i++) begin
            logic [2:0]  o;
            logic [31:0] x, y;
            o = 3'($urandom_range(0, 7));
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 7))
                0: y = 32'd0;
                1: begin x = MIN_INT; y = 32'hFFFF_FFFF; end
                2: y = 32'($urandom_range(1, 15));
                3: x = 32'($urandom_range(0, 100));
                4: y = -32'($urandom_range(1, 15));
                default: ;
            endcase
            issue_rand(o, x, y);
        end

        for (int g = 0; g < 3; g++) sweep(g, 4);

        repeat (3) @(negedge clk_core);
        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL missing_done: %0d expected results never appeared", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
